// File: rtl/wave_pkg.sv
// Shared constants for the waveform sequencer: ROM select codes, FSM state
// encodings and default widths.
package wave_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] WSEL_SQUARE = 2'd0;
  localparam logic [1:0] WSEL_SINE   = 2'd1;
  localparam logic [1:0] WSEL_TRI    = 2'd2;
  localparam logic [1:0] WSEL_SAW    = 2'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

endpackage

// File: rtl/phase_accum.sv
// Prescaler plus phase accumulator. Emits one tick every DIV enabled clocks,
// advances the phase on each tick and registers the carry-out as wrap.
module phase_accum
  import wave_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              halt,
  input  logic              clr,
  input  logic [ACC_W-1:0]  fword,
  output logic [ADDR_W-1:0] addr,
  output logic              tick,
  output logic              wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(DIV - 1);

  logic [PW-1:0]    cnt;
  logic [ACC_W-1:0] phase;

  // halt suppresses the tick that would otherwise start a new period while stopping
  assign tick = en & ~halt & (cnt == CNT_MAX);
  assign addr = phase[ACC_W-1 -: ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        cnt   <= '0;
        phase <= '0;
      end else if (en) begin
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + PW'(1);
        if (tick) {wrap, phase} <= {1'b0, phase} + {1'b0, fword};
      end
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Phase-accumulator sequencer for four waveform ROMs sharing one address bus.
// Optional output amplitude scaling is enabled by defining AMP_SCALE_EN.
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV     = 1,
  parameter int ROM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  // cfg: a word transfers on a clock where cfg_valid & cfg_ready are both high
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ACC_W-1:0]    cfg_fword,
  input  logic [1:0]          cfg_wsel,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [4*DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0]   sample,
  output logic                sample_valid,
  output logic                wrap,
  output logic                busy,
`ifdef AMP_SCALE_EN
  input  logic [7:0]          amp,
`endif
  output logic [1:0]          dbg_state
);

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] fword_act, fword_pend, fword_eff;
  logic [1:0]       wsel_act, wsel_pend, wsel_eff;
  logic             pend, accept, apply, halt, tick;
  logic [ROM_LAT-1:0] tick_pipe;
  logic [1:0]       wsel_pipe [ROM_LAT];
  logic [DATA_W-1:0] rom_data, out_data;

  assign cfg_ready = ~pend;
  assign accept    = cfg_valid & ~pend;
  // Pending config takes effect at once in IDLE, otherwise on the wrap cycle so
  // the tick issued in that cycle already belongs to the new waveform.
  assign apply     = pend & ((state == ST_IDLE) | wrap);
  assign fword_eff = apply ? fword_pend : fword_act;
  assign wsel_eff  = apply ? wsel_pend : wsel_act;
  assign halt      = (state == ST_STOPPING) & (wrap | (fword_act == '0));
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_RUN;
      ST_RUN:      if (stop) state_nxt = ST_STOPPING;
      ST_STOPPING: if (wrap || fword_act == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pend       <= 1'b0;
      fword_pend <= '0;
      wsel_pend  <= '0;
      fword_act  <= '0;
      wsel_act   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        fword_pend <= cfg_fword;
        wsel_pend  <= cfg_wsel;
        pend       <= 1'b1;
      end
      if (apply) begin
        fword_act <= fword_pend;
        wsel_act  <= wsel_pend;
        pend      <= 1'b0;
      end
    end
  end

  phase_accum #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DIV(DIV)) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .halt  (halt),
    .clr   (state_nxt == ST_IDLE),
    .fword (fword_eff),
    .addr  (rom_addr),
    .tick  (tick),
    .wrap  (wrap)
  );

  // Tick and its ROM select travel alongside the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_pipe <= '0;
      for (int i = 0; i < ROM_LAT; i++) wsel_pipe[i] <= '0;
    end else begin
      tick_pipe[0] <= tick;
      wsel_pipe[0] <= wsel_eff;
      for (int i = 1; i < ROM_LAT; i++) begin
        tick_pipe[i] <= tick_pipe[i-1];
        wsel_pipe[i] <= wsel_pipe[i-1];
      end
    end
  end

  assign rom_data = rom_dout[wsel_pipe[ROM_LAT-1]*DATA_W +: DATA_W];

`ifdef AMP_SCALE_EN
  logic [DATA_W+7:0] prod;
  assign prod     = rom_data * amp;
  assign out_data = prod[DATA_W+7:8];
`else
  assign out_data = rom_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick_pipe[ROM_LAT-1];
      if (tick_pipe[ROM_LAT-1]) sample <= out_data;
    end
  end

  assign busy = (state != ST_IDLE) | (|tick_pipe) | sample_valid;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed stimulus, expected samples
// queued at stimulus time and popped by a monitor on each sample strobe.
module tb_wave_sequencer;
  import wave_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // main DUT (DIV=1)
  logic        start, stop, cfg_valid, cfg_ready, sample_valid, wrap, busy;
  logic [31:0] cfg_fword, rom_dout;
  logic [1:0]  cfg_wsel, dbg_state;
  logic [11:0] rom_addr;
  logic [7:0]  sample;
  // second DUT (DIV=4)
  logic        d4_start, d4_stop, d4_cfg_valid, d4_cfg_ready, d4_sample_valid, d4_wrap, d4_busy;
  logic [31:0] d4_cfg_fword, d4_rom_dout;
  logic [1:0]  d4_cfg_wsel, d4_dbg_state;
  logic [11:0] d4_rom_addr;
  logic [7:0]  d4_sample;
`ifdef AMP_SCALE_EN
  logic [7:0]  amp = 8'h80;
`endif

  logic [7:0] exp_q[$];
  logic [7:0] d4_q[$];
  logic [7:0] exp_v, d4_v;
  int         wrap_cnt = 0;
  int         d4_last = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wave_sequencer #(.DIV(1), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_fword(cfg_fword), .cfg_wsel(cfg_wsel),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .sample(sample), .sample_valid(sample_valid),
    .wrap(wrap), .busy(busy),
`ifdef AMP_SCALE_EN
    .amp(amp),
`endif
    .dbg_state(dbg_state)
  );

  wave_sequencer #(.DIV(4), .ROM_LAT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(d4_start), .stop(d4_stop),
    .cfg_valid(d4_cfg_valid), .cfg_ready(d4_cfg_ready), .cfg_fword(d4_cfg_fword), .cfg_wsel(d4_cfg_wsel),
    .rom_addr(d4_rom_addr), .rom_dout(d4_rom_dout), .sample(d4_sample), .sample_valid(d4_sample_valid),
    .wrap(d4_wrap), .busy(d4_busy),
`ifdef AMP_SCALE_EN
    .amp(amp),
`endif
    .dbg_state(d4_dbg_state)
  );

  // Synthetic ROM contents, distinct per ROM so a wrong select is visible.
  function automatic logic [7:0] rom_val(input int k, input logic [11:0] a);
    case (k)
      0:       rom_val = a[11:4];
      1:       rom_val = a[7:0] ^ 8'hA5;
      2:       rom_val = {a[3:0], a[11:8]};
      default: rom_val = ~a[11:4];
    endcase
  endfunction

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    rom_word = {rom_val(3, a), rom_val(2, a), rom_val(1, a), rom_val(0, a)};
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] v);
`ifdef AMP_SCALE_EN
    logic [15:0] p;
    p = v * amp;
    scale = p[15:8];
`else
    scale = v;
`endif
  endfunction

  // One-clock-latency ROMs
  always @(posedge clk) begin
    rom_dout    <= rom_word(rom_addr);
    d4_rom_dout <= rom_word(d4_rom_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (wrap) wrap_cnt++;
    if (rst_n && sample_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sample_extra: got %0h expected no strobe", sample);
      end else begin
        exp_v = exp_q.pop_front();
        chk("sample", {24'd0, sample}, {24'd0, exp_v});
      end
    end
    if (rst_n && d4_sample_valid) begin
      if (d4_last >= 0) chk("d4_gap", cyc - d4_last, 4);
      d4_last = cyc;
      if (d4_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL d4_sample_extra: got %0h expected no strobe", d4_sample);
      end else begin
        d4_v = d4_q.pop_front();
        chk("d4_sample", {24'd0, d4_sample}, {24'd0, d4_v});
      end
    end
  end

  task automatic cfg_send(input logic [31:0] fw, input logic [1:0] ws);
    int ok;
    ok = 0;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_fword = fw; cfg_wsel = ws;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    chk("cfg_accept_timeout", ok, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(output int s_cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_wrap(input int bound, output int found);
    found = 0;
    for (int i = 0; i < bound; i++) begin
      if (wrap) begin found = 1; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int s, found, wc0;
    rst_n = 1'b0; start = 0; stop = 0; cfg_valid = 0; cfg_fword = '0; cfg_wsel = '0;
    d4_start = 0; d4_stop = 0; d4_cfg_valid = 0; d4_cfg_fword = '0; d4_cfg_wsel = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_addr", rom_addr, 0);
    @(negedge clk) rst_n = 1'b1;

    // square, one address step per tick
    cfg_send(32'h0010_0000, WSEL_SQUARE);
    @(negedge clk) chk("cfg_ready_pending", cfg_ready, 0);
    @(negedge clk) chk("cfg_ready_idle_apply", cfg_ready, 1);
    for (int i = 0; i < 4096; i++) exp_q.push_back(scale(rom_val(0, 12'(i))));
    for (int i = 0; i < 2048; i++) exp_q.push_back(scale(rom_val(1, 12'(2 * i))));
    pulse_start(s);
    @(negedge clk) begin chk("addr_c1", rom_addr, 0); chk("valid_c1", sample_valid, 0); end
    @(negedge clk) begin chk("addr_c2", rom_addr, 1); chk("valid_c2", sample_valid, 0); end
    @(negedge clk) begin chk("addr_c3", rom_addr, 2); chk("valid_c3", sample_valid, 1); end
    chk("busy_run", busy, 1);

    // retune in RUN: held pending until the wrap
    cfg_send(32'h0020_0000, WSEL_SINE);
    @(negedge clk) chk("cfg_ready_run_pending", cfg_ready, 0);
    wait_wrap(5000, found);
    chk("wrap1_seen", found, 1);
    chk("wrap1_cycle", cyc - s, 4096);
    chk("cfg_ready_in_wrap", cfg_ready, 0);
    @(negedge clk);
    chk("cfg_ready_after_wrap", cfg_ready, 1);
    chk("addr_step2", rom_addr, 2);

    // stop mid-period: finishes the period then idles
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rom_addr == 12'd100) begin found = 1; break; end
      @(negedge clk);
    end
    chk("addr100_seen", found, 1);
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_wrap(3000, found);
    chk("wrap2_seen", found, 1);
    chk("state_stopping", dbg_state, ST_STOPPING);
    @(negedge clk);
    chk("state_idle", dbg_state, ST_IDLE);
    chk("addr_idle", rom_addr, 0);
    chk("busy_drain", busy, 1);
    @(negedge clk) chk("busy_drop", busy, 0);
    chk("queue_drained_stop", exp_q.size(), 0);

    // zero increment: stop idles next clock, no wrap
    cfg_send(32'h0, WSEL_TRI);
    @(negedge clk) chk("cfg0_pending", cfg_ready, 0);
    @(negedge clk) chk("cfg0_applied", cfg_ready, 1);
    wc0 = wrap_cnt;
    exp_q.push_back(scale(rom_val(2, 12'd0)));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b1;
    @(negedge clk) chk("f0_state_run", dbg_state, ST_RUN);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk) chk("f0_state_stopping", dbg_state, ST_STOPPING);
    @(negedge clk) chk("f0_state_idle", dbg_state, ST_IDLE);
    repeat (10) @(negedge clk);
    chk("f0_no_wrap", wrap_cnt - wc0, 0);
    chk("f0_busy", busy, 0);
    chk("f0_queue", exp_q.size(), 0);

    // asynchronous reset in the middle of a run
    cfg_send(32'h0010_0000, WSEL_SAW);
    for (int i = 0; i < 8; i++) exp_q.push_back(scale(rom_val(3, 12'(i))));
    pulse_start(s);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin found = 1; break; end
    end
    chk("rst_run_samples", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sample", sample, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    chk("arst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // DIV=4: one strobe every four clocks
    @(negedge clk) chk("d4_cfg_ready", d4_cfg_ready, 1);
    @(posedge clk); #1 d4_cfg_valid = 1'b1; d4_cfg_fword = 32'h0010_0000; d4_cfg_wsel = WSEL_SQUARE;
    @(posedge clk); #1 d4_cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) d4_q.push_back(scale(rom_val(0, 12'(i))));
    @(posedge clk); #1 d4_start = 1'b1;
    @(posedge clk); #1 d4_start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (d4_q.size() == 0) begin found = 1; break; end
    end
    chk("d4_samples", found, 1);
    chk("d4_state_run", d4_dbg_state, ST_RUN);
    chk("d4_busy", d4_busy, 1);
    chk("d4_no_wrap", d4_wrap, 0);
    chk("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
